ram_bist_ctrl: RTL and testbench
================================

# ram_bist_ctrl

Built-in self-test sequencer that sits directly upstream of the 8-bit single-port RAM and owns its address, write and read ports during test. On `start` it writes a deterministic pattern to every location, reads each location back, and compares the result. With the complement pass compiled in, it repeats the write and read with the inverted pattern. It reports pass/fail plus the first failing address and data, so the RAM can be checked at bring-up without a testbench driving it directly.

## Interface
Parameters:
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 8, RAM data width
- `DEPTH`, 256, number of locations tested, addresses 0..DEPTH-1; must be ≤ 2^ADDR_W
- `SEED`, 8'hA5, pattern seed, DATA_W bits

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a test run; sampled only in IDLE or DONE
- `busy`  out  1  test in progress
- `done`  out  1  run finished; level, held until the next accepted `start`
- `pass`  out  1  valid while `done`=1; 1 = no mismatch
- `fail_addr`  out  ADDR_W  first mismatching address
- `fail_data`  out  DATA_W  data read at `fail_addr`
- `address`  out  ADDR_W  to RAM `address`
- `write_en`  out  1  to RAM `write_en`
- `write_data`  out  DATA_W  to RAM `write_data`
- `read_en`  out  1  to RAM `read_en`
- `read_data`  in  DATA_W  from RAM `read_data`

## Operation
- Pattern: `P(a) = a[DATA_W-1:0] ^ SEED`. The address is zero-extended when ADDR_W < DATA_W. Complement pattern is `~P(a)`.
- States: IDLE → WR_A → RD_A → (WR_B → RD_B, only with macro) → DRAIN → DONE.
  - IDLE/DONE, `start`=1 → WR_A, with addr counter = 0.
  - WR_X: assert `write_en`, `address`=cnt, `write_data`=pattern. At cnt=DEPTH-1, go to RD_X with cnt=0.
  - RD_X: assert `read_en`, `address`=cnt. At cnt=DEPTH-1, go to the next WR phase or to DRAIN.
  - DRAIN: one cycle; compares the last read. Then → DONE.
- Compare pipeline: the RAM read latency is 1 cycle. The expected value and address are registered alongside each read and compared against `read_data` in the following cycle.
- Mismatch handling:
  - The first mismatch latches `fail_addr`/`fail_data`, clears `pass`, and forces DONE on the same edge.
  - Any read issued in that cycle is discarded.
  - Later mismatches are never reported.
- `write_en` and `read_en` are never both 1. Outside WR/RD states both are 0 and `address`/`write_data` are 0.
- `start` while busy is ignored.
- Start from DONE clears `pass`, `fail_addr` and `fail_data` to their reset values.

## Timing
- Reset (async assert, synchronous deassert handled externally): state IDLE, cnt 0.
  - All outputs 0 except `pass`=1.
  - `fail_addr`=0, `fail_data`=0.
- `busy`=1 from the first cycle after `start` is accepted until DONE is entered. Its deassertion is simultaneous with `done` rising.
- Clean run, no macro: 2·DEPTH + 1 cycles from accept to `done` (DEPTH=256 → 513).
- Clean run, with macro: 4·DEPTH + 1 cycles (1025).
- Fail at address a in read phase A: `done` rises 2 edges after the read of a is issued.
- `rst_n` low mid-run returns the block to IDLE immediately and drops RAM enables asynchronously.
- Counter wrap: cnt never exceeds DEPTH-1. With DEPTH=2^ADDR_W, the transition occurs at all-ones without overflow dependence.

## Configuration
- `RAM_BIST_COMPLEMENT_EN`:
  - Defined: WR_B/RD_B are compiled in and the second pass uses `~P(a)`. This detects stuck-at faults in both polarities.
  - Undefined: WR_A/RD_A only; the states and pattern inverter are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset with `rst_n`=0 mid-WR_A at cnt=0x40 → next cycle `busy`=0, `done`=0, `write_en`=0, `read_en`=0, `pass`=1, state IDLE.
- Fault-free RAM, pulse `start` → write of addr 2 carries data 0xA7. `done`=1, `pass`=1 after exactly 513 cycles (1025 with macro).
- RAM model forcing bit 0 at addr 0x37 → `pass`=0, `fail_addr`=0x37, `fail_data`=0x93 (expected 0x92), no reads after addr 0x38.
- RAM model stuck-at-1 on bit 7 of addr 0x10, macro defined → phase A passes (0xB5). Phase B fails with `fail_addr`=0x10, `fail_data`=0xCA. Without the macro → `pass`=1.
- `start` held high throughout a run → no restart while busy. A new run begins on the cycle after DONE, and `pass`/`fail_*` are cleared.
- Protocol monitor over full run → `write_en`&`read_en` never 1 together. Addresses are sequential 0..255 in each phase.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// BIST sequencer for the 8-bit single-port RAM: write pattern, read back, compare.
// Optional macro RAM_BIST_COMPLEMENT_EN adds a second pass with the inverted pattern.
module ram_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter logic [DATA_W-1:0] SEED = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic [DATA_W-1:0] write_data,
    output logic              read_en,
    input  logic [DATA_W-1:0] read_data
);

`ifdef RAM_BIST_COMPLEMENT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_RD_A, S_WR_B, S_RD_B, S_DRAIN, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_RD_A, S_DRAIN, S_DONE
    } state_t;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]   fail_data_q, fail_data_d;

    logic                cnt_last;
    logic [DATA_W-1:0]   pat;
    logic                mismatch;

    assign cnt_last = (cnt_q == ADDR_W'(DEPTH - 1));
    assign pat      = DATA_W'(cnt_q) ^ SEED;
    assign mismatch = cmp_vld_q && (read_data != cmp_exp_q);

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

    // State, counter, compare pipeline and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            pass_q      <= 1'b1;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    // Sequencing, RAM port drive and first-mismatch capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmp_vld_d   = 1'b0;
        cmp_addr_d  = cmp_addr_q;
        cmp_exp_d   = cmp_exp_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        address     = '0;
        write_en    = 1'b0;
        write_data  = '0;
        read_en     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WR_A;
                    cnt_d       = '0;
                    pass_d      = 1'b1;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_WR_A: begin
                write_en   = 1'b1;
                address    = cnt_q;
                write_data = pat;
                cnt_d      = cnt_last ? '0 : cnt_q + ADDR_W'(1);
                if (cnt_last) state_d = S_RD_A;
            end
            S_RD_A: begin
                read_en    = 1'b1;
                address    = cnt_q;
                cmp_vld_d  = 1'b1;
                cmp_addr_d = cnt_q;
                cmp_exp_d  = pat;
                cnt_d      = cnt_last ? '0 : cnt_q + ADDR_W'(1);
`ifdef RAM_BIST_COMPLEMENT_EN
                if (cnt_last) state_d = S_WR_B;
`else
                if (cnt_last) state_d = S_DRAIN;
`endif
            end
`ifdef RAM_BIST_COMPLEMENT_EN
            S_WR_B: begin
                write_en   = 1'b1;
                address    = cnt_q;
                write_data = ~pat;
                cnt_d      = cnt_last ? '0 : cnt_q + ADDR_W'(1);
                if (cnt_last) state_d = S_RD_B;
            end
            S_RD_B: begin
                read_en    = 1'b1;
                address    = cnt_q;
                cmp_vld_d  = 1'b1;
                cmp_addr_d = cnt_q;
                cmp_exp_d  = ~pat;
                cnt_d      = cnt_last ? '0 : cnt_q + ADDR_W'(1);
                if (cnt_last) state_d = S_DRAIN;
            end
`endif
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A mismatch ends the run at once; the read issued this cycle is dropped
        if (mismatch) begin
            state_d     = S_DONE;
            cnt_d       = '0;
            cmp_vld_d   = 1'b0;
            pass_d      = 1'b0;
            fail_addr_d = cmp_addr_q;
            fail_data_d = read_data;
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl with a fault-injecting RAM model.
// Expectations follow RAM_BIST_COMPLEMENT_EN when it is defined.
module tb_ram_bist_ctrl;

    localparam int DEPTH = 256;
`ifdef RAM_BIST_COMPLEMENT_EN
    localparam int NPH = 2;
`else
    localparam int NPH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [7:0] fail_addr, fail_data;
    logic [7:0] address, write_data;
    logic       write_en, read_en;
    logic [7:0] read_data = '0;

    int checks = 0;
    int failures = 0;

    // RAM fault: location, bit mask, polarity (1 = stuck-at-1)
    int         flt_addr = -1;
    logic [7:0] flt_mask = '0;
    bit         flt_pol = 1'b0;

    logic [7:0] mem [DEPTH];

    int proto_err = 0;
    int addr_err = 0;
    int wdata_err = 0;
    int exp_wr = 0;
    int exp_rd = 0;
    int nwr = 0;
    int nrd = 0;
    int last_rd = -1;
    logic [7:0] wr2 = '0;

    ram_bist_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .address    (address),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] faulty(input int a, input logic [7:0] d);
        if (a == flt_addr)
            return flt_pol ? (d | flt_mask) : (d & ~flt_mask);
        return d;
    endfunction

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (write_en) mem[address] <= write_data;
        if (read_en) read_data <= faulty(int'(address), mem[address]);
    end

    // Protocol monitor: exclusive enables, sequential addresses, pattern data
    always @(negedge clk) begin
        if (!busy) begin
            exp_wr = 0;
            exp_rd = 0;
            nwr = 0;
            nrd = 0;
        end
        if (write_en && read_en) proto_err++;
        if (write_en) begin
            if (int'(address) != exp_wr) addr_err++;
            if (write_data !== ((address ^ 8'hA5) ^ ((nwr >= DEPTH) ? 8'hFF : 8'h00)))
                wdata_err++;
            if (address == 8'd2 && nwr < DEPTH) wr2 = write_data;
            exp_wr = (exp_wr + 1) % DEPTH;
            nwr++;
        end
        if (read_en) begin
            if (int'(address) != exp_rd) addr_err++;
            last_rd = int'(address);
            exp_rd = (exp_rd + 1) % DEPTH;
            nrd++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-run outcome from the pattern rules and the fault
    task automatic model(output bit ok, output int fa, output int fd, output int cyc);
        logic [7:0] wr;
        logic [7:0] rd;
        ok = 1'b1;
        fa = 0;
        fd = 0;
        cyc = NPH * 2 * DEPTH + 1;
        for (int ph = 0; ph < NPH; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr = (8'(a) ^ 8'hA5) ^ ((ph == 1) ? 8'hFF : 8'h00);
                rd = faulty(a, wr);
                if (ok && rd != wr) begin
                    ok = 1'b0;
                    fa = a;
                    fd = int'(rd);
                    cyc = ph * 2 * DEPTH + DEPTH + a + 2;
                end
            end
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_run(input string tag, input bit ep, input int efa,
                          input int efd, input int ecyc);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".busy_on"}, busy, 1);
        chk({tag, ".done_off"}, done, 0);
        wait_done(cyc);
        chk({tag, ".cycles"}, cyc, ecyc);
        chk({tag, ".busy_off"}, busy, 0);
        chk({tag, ".pass"}, pass, ep);
        chk({tag, ".fail_addr"}, fail_addr, efa);
        chk({tag, ".fail_data"}, fail_data, efd);
        chk({tag, ".proto"}, proto_err, 0);
        chk({tag, ".addr_seq"}, addr_err, 0);
        chk({tag, ".wdata"}, wdata_err, 0);
    endtask

    initial begin
        bit ok;
        int fa, fd, cyc, k;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 1);
        chk("rst.fail_addr", fail_addr, 0);
        chk("rst.fail_data", fail_data, 0);
        chk("rst.we", write_en, 0);
        chk("rst.re", read_en, 0);
        chk("rst.addr", address, 0);
        chk("rst.wdata", write_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run("clean", 1'b1, 0, 0, NPH * 2 * DEPTH + 1);
        chk("clean.wr2", wr2, 8'hA7);

        flt_addr = 8'h37;
        flt_mask = 8'h01;
        flt_pol = 1'b1;
        do_run("bit0_37", 1'b0, 8'h37, 8'h93, DEPTH + 8'h37 + 2);
        chk("bit0_37.last_rd", last_rd, 8'h38);
        chk("bit0_37.nrd", nrd, 8'h39);

        flt_addr = 8'h10;
        flt_mask = 8'h80;
        flt_pol = 1'b1;
`ifdef RAM_BIST_COMPLEMENT_EN
        do_run("b7_10", 1'b0, 8'h10, 8'hCA, 3 * DEPTH + 8'h10 + 2);
`else
        do_run("b7_10", 1'b1, 0, 0, 2 * DEPTH + 1);
`endif

        flt_addr = 8'h37;
        flt_mask = 8'h01;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(cyc);
        chk("hold.cycles1", cyc, DEPTH + 8'h37 + 2);
        chk("hold.pass1", pass, 0);
        chk("hold.fa1", fail_addr, 8'h37);
        flt_mask = 8'h00;
        @(posedge clk);
        #1;
        chk("hold.restart_busy", busy, 1);
        chk("hold.restart_done", done, 0);
        chk("hold.clr_pass", pass, 1);
        chk("hold.clr_fa", fail_addr, 0);
        chk("hold.clr_fd", fail_data, 0);
        start = 1'b0;
        wait_done(cyc);
        chk("hold.cycles2", cyc, NPH * 2 * DEPTH + 1);
        chk("hold.pass2", pass, 1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!(write_en && address == 8'h40) && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("midrst.at40", address, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("midrst.we_async", write_en, 0);
        chk("midrst.re_async", read_en, 0);
        @(posedge clk);
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.done", done, 0);
        chk("midrst.pass", pass, 1);
        chk("midrst.addr", address, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            flt_addr = int'($urandom_range(0, DEPTH - 1));
            flt_mask = 8'(1 << $urandom_range(0, 7));
            flt_pol = 1'($urandom_range(0, 1));
            model(ok, fa, fd, cyc);
            do_run($sformatf("rnd%0d", r), ok, fa, fd, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
